noise_matrix_reader: RTL
========================

# noise_matrix_reader

Read-side counterpart of the noise matrix filler. Once the filler has loaded a square noise matrix into BRAM, this block streams it out of the same BRAM on the read port in row-major order. The output is a valid/ready stream with row and frame markers, feeding the generator's first convolution/upsampling stage. Matrix size uses the same 3-bit size code as the filler, so one control word drives both blocks.

## Interface
- DATA_WIDTH, 16, width of one noise sample (Q3.13 signed, passed through unmodified)
- ADDR_WIDTH, 14, BRAM address width (covers 128x128 = 16384 words)
- clk  input  1  single clock, all logic rising-edge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  level request; starts a stream from IDLE
- size  input  3  000=4x4, 001=8x8, 010=16x16, 011=32x32, 100=64x64, 101=128x128, others=128x128
- bram_addr  output  ADDR_WIDTH  BRAM read address
- bram_en  output  1  BRAM read enable; one read per cycle it is high
- bram_rdata  input  DATA_WIDTH  BRAM read data, valid exactly 1 cycle after the bram_en cycle
- m_data  output  DATA_WIDTH  stream sample
- m_valid  output  1  stream sample valid
- m_ready  input  1  downstream accepts the sample
- m_row_last  output  1  sample is the last element of a row
- m_last  output  1  sample is the last element of the matrix
- busy  output  1  high from the cycle after start is accepted until done is asserted
- done  output  1  stream finished; handshake with start

## Operation
- States:
  - IDLE -> RUN when start=1 and done=0. On that edge, size is latched to limit = N*N-1 and row width W = 4<<size (W=128 for codes >=101). Read and output counters clear to 0.
  - RUN -> DONE on the edge where the beat with m_last=1 is accepted (m_valid & m_ready).
  - DONE: done=1, busy=0. Move to IDLE on the first edge with start=0; done drops in the same transition.
- start in RUN or DONE is ignored. size changes after the start edge are ignored.
- Read issue in RUN: bram_en=1 when read_idx <= limit and (fifo_count + inflight - pop) < 2.
  - pop = output handshake this cycle; inflight = bram_en of the previous cycle.
  - bram_addr = read_idx; read_idx increments on each issue.
  - bram_addr holds its last value when not issuing and never exceeds limit.
- Output buffer: 2-entry FIFO. bram_rdata is written into it the cycle after issue.
  - m_valid = FIFO not empty; m_data = FIFO head (registered).
  - Because the credit counts the same-cycle pop, the FIFO never overflows and no read data is dropped.
- Output index out_idx counts accepted beats. It is carried per FIFO entry, so the markers stay aligned with the data.
  - m_row_last = (out_idx & (W-1)) == W-1
  - m_last = (out_idx == limit)
- m_data, m_row_last and m_last are stable while m_valid=1 and m_ready=0.
- Exactly limit+1 beats per stream. No duplication, no reordering; beat k carries BRAM word k.

## Timing
- Reset values: bram_addr=0, bram_en=0, m_data=0, m_valid=0, m_row_last=0, m_last=0, busy=0, done=0, FIFO empty, state IDLE.
- Reset asserted mid-stream: all of the above take effect immediately. The next start restarts at address 0. No residual beat may appear.
- Start latency, with start sampled at edge E0:
  - bram_en=1, bram_addr=0 during E0..E1
  - FIFO write at E2; m_valid=1 after E2
- Throughput: 1 beat/cycle sustained while m_ready=1.
- Backpressure: with m_ready=0, at most 2 reads are outstanding beyond the head beat, and bram_en drops within 1 cycle.
- Completion:
  - done rises on the edge after the final handshake; busy falls on the same edge.
  - If start is already 0 at that point, done stays high for exactly 1 cycle.
  - If start stays high, done stays high until start=0, and no restart occurs.
- bram_en is 0 in IDLE and DONE.

## Test plan
- Size 000, BRAM[k]=k, m_ready=1:
  - 16 beats with data 0..15 on consecutive cycles, first beat 2 cycles after the start edge
  - m_row_last at beats 3, 7, 11 and 15; m_last only at beat 15
  - done high for 1 cycle if start was dropped at beat 5
- Size 011 with random m_ready (50%):
  - 1024 beats with data equal to BRAM contents in order; markers every 32 beats
  - bram_addr never exceeds 1023; FIFO never overflows (assertion)
- Size code 111 (default):
  - 16384 beats, m_last at beat 16383, final bram_addr=16383
  - busy high for the whole stream
- start held high after done:
  - done stays 1, no new bram_en; lowering start returns to IDLE
  - a second start of size 001 streams 64 beats starting at address 0
- start pulsed during RUN, and size changed mid-stream:
  - no effect; beat count matches the size latched at the original start
- rst_n asserted at beat 100 of a size 100 stream:
  - all outputs at reset values the same cycle
  - the next start streams 4096 beats starting with BRAM[0]

Source files
------------

// File: rtl/noise_matrix_reader.sv
// Streams a square noise matrix out of BRAM in row-major order
// as a valid/ready stream with row and frame end markers.
module noise_matrix_reader #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [2:0]            size,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_rdata,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_row_last,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]            r_state;
  logic [ADDR_WIDTH-1:0] r_limit;
  logic [6:0]            r_mask;
  logic [ADDR_WIDTH:0]   r_rd_idx;
  logic [ADDR_WIDTH-1:0] r_addr_hold;
  logic [ADDR_WIDTH-1:0] r_inf_idx;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_dmem [2];
  logic [ADDR_WIDTH-1:0] r_imem [2];
  logic                  r_wptr;
  logic                  r_rptr;
  logic [1:0]            r_count;

  logic [ADDR_WIDTH-1:0] w_lim_n;
  logic [6:0]            w_mask_n;
  logic                  w_start;
  logic                  w_valid;
  logic                  w_pop;
  logic [2:0]            w_credit;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [ADDR_WIDTH-1:0] w_head_idx;
  logic                  w_last_beat;

  always_comb begin
    w_lim_n  = ADDR_WIDTH'(16383);
    w_mask_n = 7'd127;
    case (size)
      3'd0: begin w_lim_n = ADDR_WIDTH'(15);   w_mask_n = 7'd3;  end
      3'd1: begin w_lim_n = ADDR_WIDTH'(63);   w_mask_n = 7'd7;  end
      3'd2: begin w_lim_n = ADDR_WIDTH'(255);  w_mask_n = 7'd15; end
      3'd3: begin w_lim_n = ADDR_WIDTH'(1023); w_mask_n = 7'd31; end
      3'd4: begin w_lim_n = ADDR_WIDTH'(4095); w_mask_n = 7'd63; end
      default: begin
        w_lim_n  = ADDR_WIDTH'(16383);
        w_mask_n = 7'd127;
      end
    endcase
  end

  // Credit includes the same-cycle pop so the 2-entry buffer never overflows
  assign w_start    = (r_state == S_IDLE) && start;
  assign w_valid    = (r_count != 2'd0);
  assign w_pop      = w_valid && m_ready;
  assign w_credit   = {1'b0, r_count} + {2'b00, r_inflight}
                    - {2'b00, w_pop};
  assign w_issue    = (r_state == S_RUN)
                    && (r_rd_idx <= {1'b0, r_limit})
                    && (w_credit < 3'd2);
  assign w_addr     = w_issue ? r_rd_idx[ADDR_WIDTH-1:0] : r_addr_hold;
  assign w_head_idx = r_imem[r_rptr];
  assign w_last_beat = w_pop && (w_head_idx == r_limit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_limit <= '0;
      r_mask  <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_RUN;
          r_limit <= w_lim_n;
          r_mask  <= w_mask_n;
        end
        S_RUN:  if (w_last_beat) r_state <= S_DONE;
        S_DONE: if (!start) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_idx    <= '0;
      r_addr_hold <= '0;
      r_inf_idx   <= '0;
      r_inflight  <= 1'b0;
    end else begin
      if (w_start) r_rd_idx <= '0;
      else if (w_issue) r_rd_idx <= r_rd_idx + 1'b1;
      r_addr_hold <= w_addr;
      r_inflight  <= w_issue;
      if (w_issue) r_inf_idx <= w_addr;
    end
  end

  // Each entry carries its word index so markers stay aligned with data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dmem[0] <= '0;
      r_dmem[1] <= '0;
      r_imem[0] <= '0;
      r_imem[1] <= '0;
      r_wptr    <= 1'b0;
      r_rptr    <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (r_inflight) begin
        r_dmem[r_wptr] <= bram_rdata;
        r_imem[r_wptr] <= r_inf_idx;
        r_wptr         <= ~r_wptr;
      end
      if (w_pop) r_rptr <= ~r_rptr;
      r_count <= r_count + {1'b0, r_inflight} - {1'b0, w_pop};
    end
  end

  assign bram_en    = w_issue;
  assign bram_addr  = w_addr;
  assign m_data     = r_dmem[r_rptr];
  assign m_valid    = w_valid;
  assign m_row_last = w_valid && ((w_head_idx[6:0] & r_mask) == r_mask);
  assign m_last     = w_valid && (w_head_idx == r_limit);
  assign busy       = (r_state == S_RUN);
  assign done       = (r_state == S_DONE);

endmodule
